mod_inv_binary: RTL
===================

// Module: mod_inv_binary
// PURPOSE
//  Parametrised modular-inverse engine for NTT twiddle/scaling precompute (e.g. n^-1, w^-1 mod q).
//  Computes inv = a^-1 mod m with the binary extended-Euclid algorithm, one step per clock.
//  Bounded latency replaces brute-force search. Adds valid/ready handshakes, operand checking and a status code.
//  Sits between the twiddle-table generator and the NTT/INTT scaling stage.
// PARAMETERS
//  WIDTH  17  bit width of a, m and inv; m <= 2^WIDTH-1
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      a/m presented
//  in_ready   out  1      engine can accept: (state==IDLE) && !reset
//  a          in   WIDTH  value to invert
//  m          in   WIDTH  modulus
//  out_valid  out  1      inv/status valid; held until out_ready
//  out_ready  in   1      consumer accepts result
//  inv        out  WIDTH  a^-1 mod m, in [1,m-1]; 0 when status!=OK
//  status     out  2      00 OK, 01 NOT_INVERTIBLE (gcd>1, incl a==0), 10 BAD_MOD (m even or m<3), 11 A_RANGE (a>=m)
// BEHAVIOUR
//  Reset (async): state=IDLE; out_valid=0; inv=0; status=00; u,v,x1,x2 cleared. An in-flight op is discarded, no result.
//  FSM IDLE->RUN->DONE->IDLE. Accept when in_valid&&in_ready; a and m are latched on that edge.
//  Accept checks, priority BAD_MOD > A_RANGE: on failure go IDLE->DONE directly, inv=0. No RUN cycles.
//  Otherwise load u=a, v=m, x1=1, x2=0, go RUN.
//  RUN: each cycle evaluates terminal tests first, in this order:
//   u==1 -> inv=x1, status=OK, go DONE.
//   v==1 -> inv=x2, status=OK, go DONE.
//   u==0 or v==0 -> inv=0, status=NOT_INVERTIBLE, go DONE.
//  If no terminal test fires, exactly one step, in priority order:
//   u even: u=u>>1; x1 = x1 even ? x1>>1 : (x1+m)>>1.
//   v even: v=v>>1; x2 updated the same way.
//   u>=v: u=u-v; x1 = x1>=x2 ? x1-x2 : x1-x2+m.
//   else: v=v-u; x2 = x2>=x1 ? x2-x1 : x2-x1+m.
//  Width rules: x1+m and x2+m are computed at WIDTH+1 bits, no overflow. x1 and x2 always lie in [0,m-1].
//  Invariants x1*a==u and x2*a==v (mod m) hold every cycle.
//  Latency: out_valid rises N+1 cycles after the accept edge; N = RUN cycles, 1 <= N <= 4*WIDTH+2.
//  Error-at-accept: out_valid rises on the edge after accept.
//  DONE: out_valid=1; inv and status are stable. Leaving DONE on the edge with out_ready=1 clears out_valid and returns to IDLE.
//   in_ready rises the cycle after that edge; no same-cycle accept while in DONE.
//  in_valid while busy is ignored; the upstream must hold its data. out_ready outside DONE has no effect.
//  inv and status hold their last values in IDLE/RUN and are only meaningful with out_valid.
// TESTING
//  a=3, m=7 -> out_valid, inv=5, status=00.
//  a=2, m=12289 -> inv=6145, status=00. a=256, m=12289 -> inv*256 mod 12289 == 1.
//   Latency <= 4*WIDTH+3 from accept.
//  a=1, m=7681 -> inv=1 with out_valid 2 cycles after accept.
//   a=131070, m=131071 -> inv=131070.
//  a=6, m=9 -> status=01, inv=0. a=0, m=7 -> status=01.
//   m=8 -> status=10 on edge after accept. a=9, m=7 -> status=11.
//  Backpressure: hold out_ready=0 for 10 cycles -> out_valid, inv and status stable, in_ready=0.
//   Then out_ready=1 -> IDLE, and the next op is accepted.
//  Assert reset mid-RUN (a=2, m=12289) -> outputs 0 immediately, no out_valid.
//   After release, a=3, m=7 yields 5.
//   Random sweep, m odd prime <2^17: inv*a mod m==1, or status=01 iff gcd(a,m)>1.

Source files
------------

// File: rtl/mod_inv_binary.sv
// Modular inverse engine: inv = a^-1 mod m using binary extended Euclid,
// one reduction step per clock, with valid/ready handshakes and a status code.
module mod_inv_binary #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] inv,
  output logic [1:0]       status
);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NOT_INV = 2'b01;
  localparam logic [1:0] ST_BAD_MOD = 2'b10;
  localparam logic [1:0] ST_A_RANGE = 2'b11;

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] THREE = WIDTH'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] u_q, v_q, x1_q, x2_q, m_q;
  logic [WIDTH-1:0] u_d, v_d, x1_d, x2_d;
  logic [WIDTH-1:0] inv_q;
  logic [1:0]       status_q;
  logic             out_valid_q;

  logic             accept;
  logic             bad_mod;
  logic             a_range;

  // Halve x modulo odd m: add m first when x is odd so the result stays exact.
  // The sum is formed one bit wider so x+m cannot overflow.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] md);
    logic [WIDTH:0] sum;
    sum = x[0] ? ({1'b0, x} + {1'b0, md}) : {1'b0, x};
    return sum[WIDTH:1];
  endfunction

  // (p - q) mod m for p, q in [0, m-1]; wraps by adding m at WIDTH+1 bits.
  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] p,
                                               input logic [WIDTH-1:0] q,
                                               input logic [WIDTH-1:0] md);
    logic [WIDTH:0] diff;
    if (p >= q) diff = {1'b0, p} - {1'b0, q};
    else        diff = {1'b0, p} + {1'b0, md} - {1'b0, q};
    return diff[WIDTH-1:0];
  endfunction

  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign accept    = in_valid && (state_q == S_IDLE);
  assign bad_mod   = !m[0] || (m < THREE);
  assign a_range   = (a >= m);

  assign out_valid = out_valid_q;
  assign inv       = inv_q;
  assign status    = status_q;

  // One Euclid step in priority order; only used when no terminal test fires.
  always_comb begin
    u_d  = u_q;
    v_d  = v_q;
    x1_d = x1_q;
    x2_d = x2_q;
    if (!u_q[0]) begin
      u_d  = u_q >> 1;
      x1_d = half_mod(x1_q, m_q);
    end else if (!v_q[0]) begin
      v_d  = v_q >> 1;
      x2_d = half_mod(x2_q, m_q);
    end else if (u_q >= v_q) begin
      u_d  = u_q - v_q;
      x1_d = sub_mod(x1_q, x2_q, m_q);
    end else begin
      v_d  = v_q - u_q;
      x2_d = sub_mod(x2_q, x1_q, m_q);
    end
  end

  // Control FSM with registered result, status and out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      u_q         <= '0;
      v_q         <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      m_q         <= '0;
      inv_q       <= '0;
      status_q    <= ST_OK;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            m_q <= m;
            if (bad_mod) begin
              inv_q       <= '0;
              status_q    <= ST_BAD_MOD;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (a_range) begin
              inv_q       <= '0;
              status_q    <= ST_A_RANGE;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              u_q     <= a;
              v_q     <= m;
              x1_q    <= ONE;
              x2_q    <= '0;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (u_q == ONE) begin
            inv_q       <= x1_q;
            status_q    <= ST_OK;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (v_q == ONE) begin
            inv_q       <= x2_q;
            status_q    <= ST_OK;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if ((u_q == '0) || (v_q == '0)) begin
            inv_q       <= '0;
            status_q    <= ST_NOT_INV;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            u_q  <= u_d;
            v_q  <= v_d;
            x1_q <= x1_d;
            x2_q <= x2_d;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
